vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

- Receive-side counterpart of `vga_controller`.
- Samples the `hs`/`vs` sync stream and recovers the pixel coordinates (`DrawX`, `DrawY`) and the active-video flag.
- Locks to the 800×525 / 640×480 timing and flags any sync pulse that does not arrive where the timing predicts.
- Placed beside the VGA path as an on-chip timing monitor: checks the generated sync against the geometry that `color_mapper` consumes, with errors counted for the HEX/LED debug outputs.

## Interface

Parameters:
- `H_TOTAL`, 800: pixels per line.
- `H_VISIBLE`, 640: active pixels per line.
- `H_SYNC_START`, 656: `DrawX` value of the first pixel with `hs` low.
- `V_TOTAL`, 525: lines per frame.
- `V_VISIBLE`, 480: active lines per frame.
- `V_SYNC_START`, 490: `DrawY` value of the first line with `vs` low.

Ports:
- `Clk` input 1: single clock. Reset is synchronous and active-high; `Clk` is the only clock.
- `Reset` input 1: synchronous, active-high.
- `pix_en` input 1: pixel strobe. Tie high when `Clk` is the pixel clock.
- `hs` input 1: horizontal sync, active low.
- `vs` input 1: vertical sync, active low.
- `DrawX` output 10: recovered column.
- `DrawY` output 10: recovered row.
- `active` output 1: high when `locked`, `DrawX` < `H_VISIBLE` and `DrawY` < `V_VISIBLE`.
- `locked` output 1: timing acquired.
- `frame_start` output 1: one-`Clk` pulse when `DrawX`/`DrawY` wrap to (0,0) while locked.
- `sync_err` output 1: one-`Clk` pulse on a misplaced or missing sync.
- `err_count` output 8: saturating error count.

## Operation

- Registers `hs_q`/`vs_q` sample `hs`/`vs` on each `pix_en`.
  - hs edge: `hs`=0 && `hs_q`=1.
  - vs edge: `vs`=0 && `vs_q`=1.
- Prediction: `px` = `DrawX`+1, wrapping `H_TOTAL`-1 → 0.
  - `py` advances only when `px` wraps, wrapping `V_TOTAL`-1 → 0.
- By default, each `pix_en` loads `DrawX`←`px` and `DrawY`←`py`. States override this as follows.
- SEARCH:
  - `locked`=0.
  - On hs edge: `DrawX`←`H_SYNC_START`, go to HACQ.
- HACQ:
  - On hs edge with `px`==`H_SYNC_START`: go to VACQ.
  - On hs edge otherwise: reload `DrawX`←`H_SYNC_START`, stay in HACQ.
- VACQ:
  - Horizontal checks apply; a failure returns to SEARCH with no error reported.
  - On vs edge with `px`==0: `DrawY`←`V_SYNC_START`, go to LOCKED.
- LOCKED: `locked`=1. An error is any of:
  - hs edge with `px`≠`H_SYNC_START`;
  - `px`==`H_SYNC_START` without an hs edge;
  - vs edge with (`px`,`py`)≠(0,`V_SYNC_START`);
  - (`px`,`py`)==(0,`V_SYNC_START`) without a vs edge.
- On error:
  - `sync_err` pulses and `err_count` increments, saturating at 255.
  - State goes to SEARCH and `locked` drops the same cycle `sync_err` asserts.
  - Several error conditions in one sample count once.
- Simultaneous hs and vs edges in LOCKED: evaluated as above. Both can never be legal together, so the result is one error.

## Timing

- Reset values: `DrawX`=0, `DrawY`=0, `active`=0, `locked`=0, `frame_start`=0, `sync_err`=0, `err_count`=0, state SEARCH.
- Reset mid-frame clears everything on the next `Clk`. `err_count` is cleared too.
- Latency: outputs describe the pixel sampled on the previous `pix_en` (1 `Clk` after the sample).
- `pix_en`=0:
  - Counters, state and sync history hold.
  - `frame_start`/`sync_err` are low.
  - Pulses are always exactly one `Clk` wide.
- Lock latency from SEARCH with ideal input:
  - Two hs edges are needed (≤ 2 lines).
  - The next vs edge follows (≤ 1 frame).
  - `locked` rises on the `Clk` after the sample carrying the vs edge.
- `frame_start` is first emitted at the first wrap to (0,0) after lock. It then repeats every `H_TOTAL`×`V_TOTAL` = 420000 `pix_en` samples.

## Configuration

- `VGA_SYNC_DECODER_ERRCNT_EN` defined: the 8-bit saturating `err_count` register is built.
- Not defined: `err_count` is constant 0 and the register is omitted. `sync_err` and all state behaviour are unchanged.

## Test plan

- Reset, then drive `vga_controller` output with `pix_en`=1:
  - `locked` rises by the first vs edge.
  - Thereafter `DrawX`/`DrawY` equal the generator counters delayed by 1 cycle.
  - `active` matches the generator's `blank`.
- Locked for 3 frames: exactly 3 `frame_start` pulses, spaced 420000 cycles; `sync_err` never asserts.
- Suppress one hs pulse at line 100 while locked:
  - `sync_err` pulses at predicted `DrawX`=656, `err_count`=1, `locked`=0.
  - Relock occurs within one frame.
- Lines of 799 pixels: the block stays in HACQ, `locked` stays 0 and `err_count` stays 0.
- Inject 300 misplaced vs edges with relock between them:
  - `err_count` saturates at 255.
  - Macro undefined: `err_count`=0 throughout while `sync_err` still pulses.
- `pix_en` toggling 1-of-2 with a 50 MHz `Clk`, then `Reset` asserted mid-frame:
  - Lock and coordinates are identical per enabled sample.
  - After reset, all outputs are 0 on the next cycle and lock is reacquired.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// Sync-stream inputs and recovered-timing outputs of vga_sync_decoder.
// master drives the sync stream; slave is the decoder side.
interface vga_sync_decoder_if;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       active;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [7:0] err_count;

    modport master (
        output pix_en, hs, vs,
        input  DrawX, DrawY, active, locked, frame_start, sync_err, err_count
    );

    modport slave (
        input  pix_en, hs, vs,
        output DrawX, DrawY, active, locked, frame_start, sync_err, err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Purpose: recovers DrawX/DrawY/active from an hs/vs stream, flags misplaced or missing sync.
// Latency: outputs describe the sample taken on the previous pix_en (1 Clk).
// Backpressure: none; pix_en=0 holds all state. VGA_SYNC_DECODER_ERRCNT_EN builds err_count.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490
) (
    input  logic              Clk,
    input  logic              Reset,
    vga_sync_decoder_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, HACQ, VACQ, LOCKED} state_t;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);

    state_t     state_q, state_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic [9:0] drawx_q, drawx_d, drawy_q, drawy_d;
    logic       frame_start_q, frame_start_d;
    logic       sync_err_q, sync_err_d;

    logic       hs_edge, vs_edge;
    logic [9:0] px, py;
    logic       h_bad, v_bad;

    // Prediction of the coordinate the current sample should carry.
    always_comb begin
        hs_edge = !bus.hs && hs_q;
        vs_edge = !bus.vs && vs_q;
        px      = (drawx_q == H_LAST) ? 10'd0 : drawx_q + 10'd1;
        py      = drawy_q;
        if (drawx_q == H_LAST) begin
            py = (drawy_q == V_LAST) ? 10'd0 : drawy_q + 10'd1;
        end
        h_bad = hs_edge != (px == H_SS);
        v_bad = vs_edge != ((px == 10'd0) && (py == V_SS));
    end

    always_comb begin
        state_d       = state_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        drawx_d       = drawx_q;
        drawy_d       = drawy_q;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;
        if (bus.pix_en) begin
            hs_d    = bus.hs;
            vs_d    = bus.vs;
            drawx_d = px;
            drawy_d = py;
            unique case (state_q)
                SEARCH: begin
                    if (hs_edge) begin
                        drawx_d = H_SS;
                        state_d = HACQ;
                    end
                end
                HACQ: begin
                    if (hs_edge) begin
                        if (px == H_SS) state_d = VACQ;
                        else            drawx_d = H_SS;
                    end
                end
                VACQ: begin
                    // Losing horizontal alignment here is not an error, just a restart.
                    if (h_bad) begin
                        state_d = SEARCH;
                    end else if (vs_edge && (px == 10'd0)) begin
                        drawy_d = V_SS;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (h_bad || v_bad) begin
                        sync_err_d = 1'b1;
                        state_d    = SEARCH;
                    end else begin
                        frame_start_d = (px == 10'd0) && (py == 10'd0);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            drawx_q       <= 10'd0;
            drawy_q       <= 10'd0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            drawx_q       <= drawx_d;
            drawy_q       <= drawy_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (sync_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) err_count_q <= 8'd0;
        else       err_count_q <= err_count_d;
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = 8'd0;
`endif

    assign bus.DrawX       = drawx_q;
    assign bus.DrawY       = drawy_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.active      = (state_q == LOCKED) && (drawx_q < H_VIS) && (drawy_q < V_VIS);
    assign bus.frame_start = frame_start_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 16x8 geometry (10x5 visible).
module tb_vga_sync_decoder;
    localparam int HT  = 16;
    localparam int HV  = 10;
    localparam int HSS = 12;
    localparam int HSW = 2;
    localparam int VT  = 8;
    localparam int VV  = 5;
    localparam int VSS = 6;
    localparam int FRAME = HT * VT;

    logic Clk = 1'b0;
    logic Reset;
    vga_sync_decoder_if vif ();

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_VISIBLE(HV), .H_SYNC_START(HSS),
        .V_TOTAL(VT), .V_VISIBLE(VV), .V_SYNC_START(VSS)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (vif)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int gx = 0, gy = 0, h_len = HT, kill_line = -1;
    bit inj_vs = 1'b0;
    int s_x = -1, s_y = -1;
    int cyc = 0;

    function automatic int exp_cnt(input int n);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One Clk: present the generator's current pixel, then advance it if enabled.
    task automatic step(input bit en);
        vif.pix_en = en;
        vif.hs = !((gx >= HSS) && (gx < HSS + HSW) && (gy != kill_line));
        vif.vs = !((gy == VSS) || (inj_vs && gy == 2 && gx == 3));
        @(posedge Clk);
        #1;
        cyc++;
        if (en) begin
            s_x = gx;
            s_y = gy;
            if (gx == h_len - 1) begin
                gx = 0;
                gy = (gy == VT - 1) ? 0 : gy + 1;
            end else begin
                gx++;
            end
        end
    endtask

    task automatic run_to(input int x, input int y, input string tag);
        int n = 0;
        do begin
            step(1'b1);
            n++;
        end while (!(s_x == x && s_y == y) && n < 400);
        chk(tag, 32'(s_x == x && s_y == y), 1);
    endtask

    task automatic wait_lock(input bit alt, input string tag);
        int n = 0;
        while (!vif.locked && n < 700) begin
            step(1'b1);
            if (alt) step(1'b0);
            n++;
        end
        chk(tag, vif.locked, 1);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_x"},   vif.DrawX, 0);
        chk({tag, "_y"},   vif.DrawY, 0);
        chk({tag, "_act"}, vif.active, 0);
        chk({tag, "_lck"}, vif.locked, 0);
        chk({tag, "_fs"},  vif.frame_start, 0);
        chk({tag, "_err"}, vif.sync_err, 0);
        chk({tag, "_cnt"}, vif.err_count, 0);
    endtask

    initial begin
        int n, fs, last_fs, err_seen;

        // Reset state
        Reset = 1'b1;
        step(1'b0);
        step(1'b0);
        all_zero("rst");
        Reset = 1'b0;

        // Acquire from (0,0): lock right after the sample carrying (0,VSS)
        n = 0;
        while (!vif.locked && n < 300) begin
            step(1'b1);
            n++;
        end
        chk("lock_seen", vif.locked, 1);
        chk("lock_samples", n, VSS * HT + 1);
        chk("lock_x", vif.DrawX, 0);
        chk("lock_y", vif.DrawY, VSS);
        chk("lock_cnt", vif.err_count, 0);

        // Three locked frames: tracking, active, frame_start spacing
        fs = 0; last_fs = -1; err_seen = 0;
        repeat (3 * FRAME) begin
            step(1'b1);
            chk("trk_x", vif.DrawX, s_x);
            chk("trk_y", vif.DrawY, s_y);
            chk("trk_act", vif.active, 32'(s_x < HV && s_y < VV));
            if (vif.sync_err) err_seen++;
            if (vif.frame_start) begin
                chk("fs_pos", 32'(s_x == 0 && s_y == 0), 1);
                if (last_fs >= 0) chk("fs_gap", cyc - last_fs, FRAME);
                last_fs = cyc;
                fs++;
            end
        end
        chk("fs_count", fs, 3);
        chk("no_err", err_seen, 0);

        // Missing hs pulse on line 2
        kill_line = 2;
        run_to(HSS, 2, "reach_kill");
        chk("kill_err", vif.sync_err, 1);
        chk("kill_x", vif.DrawX, HSS);
        chk("kill_lck", vif.locked, 0);
        chk("kill_cnt", vif.err_count, exp_cnt(1));
        kill_line = -1;
        step(1'b1);
        chk("kill_pulse1", vif.sync_err, 0);
        wait_lock(1'b0, "kill_relock");
        chk("kill_relock_y", vif.DrawY, VSS);

        // Reset mid-frame
        run_to(5, 3, "reach_mid");
        Reset = 1'b1;
        step(1'b1);
        Reset = 1'b0;
        all_zero("midrst");
        wait_lock(1'b0, "midrst_relock");

        // Short lines: never gets past horizontal acquisition
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
        gx = 0; gy = 0; h_len = HT - 1;
        err_seen = 0;
        repeat (400) begin
            step(1'b1);
            if (vif.locked || vif.sync_err || vif.err_count != 0) err_seen++;
        end
        chk("short_stuck", err_seen, 0);
        chk("short_lck", vif.locked, 0);
        gx = 0; gy = 0; h_len = HT;
        wait_lock(1'b0, "short_relock");

        // Misplaced vs edges, relocking between them
        inj_vs = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            run_to(3, 2, "reach_inj");
            chk("inj_err", vif.sync_err, 1);
            chk("inj_lck", vif.locked, 0);
            chk("inj_cnt", vif.err_count, exp_cnt(k));
            wait_lock(1'b0, "inj_relock");
        end
        inj_vs = 1'b0;
        chk("sat_cnt", vif.err_count, exp_cnt(300));

        // pix_en 1-of-2
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
        all_zero("half_rst");
        wait_lock(1'b1, "half_lock");
        chk("half_lock_y", vif.DrawY, VSS);
        fs = 0;
        repeat (2 * FRAME) begin
            step(1'b1);
            chk("half_x", vif.DrawX, s_x);
            chk("half_y", vif.DrawY, s_y);
            chk("half_act", vif.active, 32'(s_x < HV && s_y < VV));
            chk("half_err", vif.sync_err, 0);
            if (vif.frame_start) fs++;
            step(1'b0);
            chk("hold_x", vif.DrawX, s_x);
            chk("hold_y", vif.DrawY, s_y);
            chk("hold_fs", vif.frame_start, 0);
            chk("hold_err", vif.sync_err, 0);
        end
        chk("half_fs_count", fs, 2);
        repeat (40) begin
            step(1'b1);
            step(1'b0);
        end
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
        all_zero("half_midrst");
        wait_lock(1'b1, "half_relock");
        chk("half_relock_y", vif.DrawY, VSS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
